// File: rtl/execute_pipe_if.sv
// ---------------------------------------------------------------------------
// execute_pipe_if : decode->execute and execute->memory handshake/bus bundle
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface execute_pipe_if #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_imm;
  logic             in_src_imm;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_pc_inc;
  logic [WIDTH-1:0] in_br_off;
  logic             in_is_br;
  logic [1:0]       in_br_cond;
  logic             in_is_jmp;
  logic             in_jmp_reg;
  logic [RD_W-1:0]  in_rd;
  logic             in_wr_en;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_wr_en;
  logic             out_err;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;

  modport master (
    output in_valid, in_a, in_b, in_imm, in_src_imm, in_op, in_pc_inc, in_br_off,
           in_is_br, in_br_cond, in_is_jmp, in_jmp_reg, in_rd, in_wr_en, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wr_en, out_err, redirect, redirect_pc
  );

  modport slave (
    input  in_valid, in_a, in_b, in_imm, in_src_imm, in_op, in_pc_inc, in_br_off,
           in_is_br, in_br_cond, in_is_jmp, in_jmp_reg, in_rd, in_wr_en, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wr_en, out_err, redirect, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/execute_pipe.sv
// ---------------------------------------------------------------------------
// execute_pipe : registered execute stage (ALU, branch/jump resolve, EX/MEM reg)
// Optional iterative multiplier enabled by macro EXEC_MUL_EN.
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module execute_pipe #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  execute_pipe_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]        opb;
  logic [SHW-1:0]          shamt;
  logic [SHW:0]            shinv;
  logic [WIDTH:0]          sum_c;
  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_err;
  logic                    cond_ok;
  logic                    taken;
  logic [WIDTH-1:0]        target;

  logic                    slot_free;
  logic                    accept;
  logic                    ld_en;
  logic [WIDTH-1:0]        ld_result;
  logic                    ld_err;
  logic [RD_W-1:0]         ld_rd;
  logic                    ld_wr;
  logic                    ld_taken;
  logic [WIDTH-1:0]        ld_target;

  always_comb begin
    opb     = bus.in_src_imm ? bus.in_imm : bus.in_b;
    shamt   = opb[SHW-1:0];
    shinv   = (SHW+1)'(WIDTH) - {1'b0, shamt};
    sum_c   = {1'b0, bus.in_a} + {1'b0, opb};
    sa      = signed'(bus.in_a);
    sb      = signed'(opb);
    alu_res = '0;
    alu_err = 1'b0;
    case (bus.in_op)
      4'd0:  alu_res = sum_c[WIDTH-1:0];
      4'd1:  alu_res = bus.in_a - opb;
      4'd2:  alu_res = bus.in_a ^ opb;
      4'd3:  alu_res = bus.in_a & ~opb;
      // shinv == WIDTH when shamt == 0, so the wrap term vanishes
      4'd4:  alu_res = (bus.in_a << shamt) | (bus.in_a >> shinv);
      4'd5:  alu_res = bus.in_a << shamt;
      4'd6:  alu_res = (bus.in_a >> shamt) | (bus.in_a << shinv);
      4'd7:  alu_res = bus.in_a >> shamt;
      4'd8:  alu_res = {{(WIDTH-1){1'b0}}, bus.in_a == opb};
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, sa < sb};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, sa <= sb};
      4'd11: alu_res = {{(WIDTH-1){1'b0}}, sum_c[WIDTH]};
`ifdef EXEC_MUL_EN
      4'd12: alu_res = '0;
`endif
      4'd13: alu_res = opb;
      default: alu_err = 1'b1;
    endcase
    if (bus.in_is_jmp) begin
      alu_res = bus.in_pc_inc;
      alu_err = 1'b0;
    end
    case (bus.in_br_cond)
      2'b00:   cond_ok = (bus.in_a == '0);
      2'b01:   cond_ok = (bus.in_a != '0);
      2'b10:   cond_ok = bus.in_a[WIDTH-1];
      default: cond_ok = !bus.in_a[WIDTH-1];
    endcase
    taken  = bus.in_is_jmp || (bus.in_is_br && cond_ok);
    target = (bus.in_jmp_reg ? bus.in_a : bus.in_pc_inc) + bus.in_br_off;
  end

  assign slot_free = !bus.out_valid || bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;

`ifdef EXEC_MUL_EN
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic             pend_taken;
  logic [WIDTH-1:0] pend_target;
  logic [RD_W-1:0]  pend_rd;
  logic             pend_wr;
  logic             is_mul;
  logic             mul_ld;

  assign bus.in_ready = (state == IDLE) && slot_free;
  assign is_mul       = (bus.in_op == 4'd12) && !bus.in_is_jmp;
  assign mul_ld       = (state == DONE) && slot_free;

  always_comb begin
    ld_en     = (accept && !is_mul) || mul_ld;
    ld_result = mul_ld ? acc         : alu_res;
    ld_err    = mul_ld ? 1'b0        : alu_err;
    ld_rd     = mul_ld ? pend_rd     : bus.in_rd;
    ld_wr     = mul_ld ? pend_wr     : bus.in_wr_en;
    ld_taken  = mul_ld ? pend_taken  : taken;
    ld_target = mul_ld ? pend_target : target;
  end
`else
  assign bus.in_ready = slot_free;

  always_comb begin
    ld_en     = accept;
    ld_result = alu_res;
    ld_err    = alu_err;
    ld_rd     = bus.in_rd;
    ld_wr     = bus.in_wr_en;
    ld_taken  = taken;
    ld_target = target;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_result  <= '0;
      bus.out_rd      <= '0;
      bus.out_wr_en   <= 1'b0;
      bus.out_err     <= 1'b0;
      bus.redirect    <= 1'b0;
      bus.redirect_pc <= '0;
`ifdef EXEC_MUL_EN
      state       <= IDLE;
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      pend_taken  <= 1'b0;
      pend_target <= '0;
      pend_rd     <= '0;
      pend_wr     <= 1'b0;
`endif
    end else begin
      bus.redirect <= 1'b0;
      if (bus.out_valid && bus.out_ready)
        bus.out_valid <= 1'b0;
      if (ld_en) begin
        bus.out_valid  <= 1'b1;
        bus.out_result <= ld_result;
        bus.out_rd     <= ld_rd;
        bus.out_wr_en  <= ld_wr;
        bus.out_err    <= ld_err;
        if (ld_taken) begin
          bus.redirect    <= 1'b1;
          bus.redirect_pc <= ld_target;
        end
      end
`ifdef EXEC_MUL_EN
      case (state)
        IDLE: begin
          if (accept && is_mul) begin
            state       <= MUL;
            cnt         <= '0;
            mcand       <= bus.in_a;
            mplier      <= opb;
            acc         <= '0;
            pend_taken  <= taken;
            pend_target <= target;
            pend_rd     <= bus.in_rd;
            pend_wr     <= bus.in_wr_en;
          end
        end
        MUL: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= DONE;
        end
        DONE: begin
          if (slot_free)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_execute_pipe.sv
// ---------------------------------------------------------------------------
// tb_execute_pipe : table vectors, directed corner sequences, random vs model
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_execute_pipe;
  localparam int W = 16;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, imm, pc, off;
    logic        src_imm, is_br, is_jmp, jreg, wr;
    logic [1:0]  cond;
    logic [2:0]  rd;
  } instr_t;

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic [2:0]  rd;
    logic        wr;
    logic        taken;
    logic [15:0] tgt;
  } exp_t;

  typedef struct {
    string       name;
    instr_t      i;
    logic [15:0] res;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  instr_t cur;
  exp_t   q[$];

  always #5 clk = ~clk;

  execute_pipe_if #(.WIDTH(W), .RD_W(3)) bus ();
  execute_pipe #(.WIDTH(W), .RD_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    instr_t x;
    x.op = op; x.a = a; x.b = b; x.imm = 16'h0; x.src_imm = 1'b0;
    x.pc = 16'h0; x.off = 16'h0; x.is_br = 1'b0; x.cond = 2'b00;
    x.is_jmp = 1'b0; x.jreg = 1'b0; x.rd = 3'd0; x.wr = 1'b0;
    return x;
  endfunction

  // Reference computed from the instruction-set rules with plain integer arithmetic.
  function automatic exp_t model(input instr_t x);
    exp_t   e;
    longint m = 65536;
    longint a = x.a;
    longint b = x.src_imm ? x.imm : x.b;
    longint sa = (a >= 32768) ? a - m : a;
    longint sb = (b >= 32768) ? b - m : b;
    longint s = b % 16;
    longint r = 0;
    bit     err = 0;
    bit     c;
    case (x.op)
      0:  r = (a + b) % m;
      1:  r = (a - b + m) % m;
      2:  r = a ^ b;
      3:  r = a & ~b & 65535;
      4:  r = ((a << s) | (a >> (16 - s))) % m;
      5:  r = (a << s) % m;
      6:  r = ((a >> s) | (a << (16 - s))) % m;
      7:  r = a >> s;
      8:  r = (a == b) ? 1 : 0;
      9:  r = (sa < sb) ? 1 : 0;
      10: r = (sa <= sb) ? 1 : 0;
      11: r = (a + b >= m) ? 1 : 0;
`ifdef EXEC_MUL_EN
      12: r = (a * b) % m;
`endif
      13: r = b;
      default: err = 1;
    endcase
    if (x.is_jmp) begin r = x.pc; err = 0; end
    case (x.cond)
      2'b00:   c = (a == 0);
      2'b01:   c = (a != 0);
      2'b10:   c = (sa < 0);
      default: c = (sa >= 0);
    endcase
    e.res   = r[15:0];
    e.err   = err;
    e.rd    = x.rd;
    e.wr    = x.wr;
    e.taken = x.is_jmp || (x.is_br && c);
    r       = ((x.jreg ? a : longint'(x.pc)) + longint'(x.off)) % m;
    e.tgt   = r[15:0];
    return e;
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    x = mk(4'($urandom_range(0, 15)), pick16(), pick16());
    x.imm = pick16(); x.src_imm = 1'($urandom); x.pc = 16'($urandom);
    x.off = pick16(); x.is_br = ($urandom_range(0, 3) == 0);
    x.cond = 2'($urandom); x.is_jmp = ($urandom_range(0, 7) == 0);
    x.jreg = 1'($urandom); x.rd = 3'($urandom); x.wr = 1'($urandom);
`ifdef EXEC_MUL_EN
    if (x.op == 4'd12 && !x.is_jmp) x.op = 4'd0;
`endif
    return x;
  endfunction

  task automatic drive(input instr_t x);
    bus.in_op = x.op; bus.in_a = x.a; bus.in_b = x.b; bus.in_imm = x.imm;
    bus.in_src_imm = x.src_imm; bus.in_pc_inc = x.pc; bus.in_br_off = x.off;
    bus.in_is_br = x.is_br; bus.in_br_cond = x.cond; bus.in_is_jmp = x.is_jmp;
    bus.in_jmp_reg = x.jreg; bus.in_rd = x.rd; bus.in_wr_en = x.wr;
  endtask

  // Offers one instruction, confirms acceptance, returns 1 ns after the accept edge.
  task automatic send(input instr_t x, input string nm);
    @(negedge clk);
    drive(x);
    bus.in_valid = 1'b1;
    #1 chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Scoreboard: pops on each consume, pushes on each accept, checks redirect one cycle later.
  initial begin : monitor
    bit          pend = 0;
    bit          pend_taken = 0;
    logic [15:0] pend_tgt = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend) begin
          chk("rnd_redirect", 32'(bus.redirect), 32'(pend_taken));
          if (pend_taken) chk("rnd_redirect_pc", 32'(bus.redirect_pc), 32'(pend_tgt));
          pend = 0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            chk("rnd_unexpected_out", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("rnd_result", 32'(bus.out_result), 32'(e.res));
            chk("rnd_err", 32'(bus.out_err), 32'(e.err));
            chk("rnd_rd_wr", {28'd0, bus.out_rd, bus.out_wr_en}, {28'd0, e.rd, e.wr});
          end
        end
`ifndef EXEC_MUL_EN
        chk("rnd_in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
`endif
        if (bus.in_valid && bus.in_ready) begin
          e = model(cur);
          q.push_back(e);
          pend = 1; pend_taken = e.taken; pend_tgt = e.tgt;
        end
      end
    end
  end

  initial begin : stim
    vec_t   vecs[$];
    vec_t   v;
    instr_t x;
    bit     seen;

    drive(mk(4'd0, 16'h0, 16'h0));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", 32'(bus.out_result), 32'd0);
    chk("rst_redirect", {31'd0, bus.redirect} | 32'(bus.redirect_pc), 32'd0);
    chk("rst_err_rd_wr", {28'd0, bus.out_err, bus.out_rd, bus.out_wr_en}, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    vecs.push_back('{"add",      mk(4'd0,  16'h0005, 16'h0003), 16'h0008, 1'b0});
    vecs.push_back('{"sub",      mk(4'd1,  16'h0003, 16'h0005), 16'hFFFE, 1'b0});
    vecs.push_back('{"xor",      mk(4'd2,  16'hF0F0, 16'hFF00), 16'h0FF0, 1'b0});
    vecs.push_back('{"andn",     mk(4'd3,  16'hF0F0, 16'hFF00), 16'h00F0, 1'b0});
    vecs.push_back('{"rol1",     mk(4'd4,  16'h8001, 16'h0011), 16'h0003, 1'b0});
    vecs.push_back('{"rol0",     mk(4'd4,  16'h1234, 16'h0010), 16'h1234, 1'b0});
    vecs.push_back('{"sll",      mk(4'd5,  16'h00F0, 16'h0004), 16'h0F00, 1'b0});
    vecs.push_back('{"ror",      mk(4'd6,  16'h0001, 16'h0001), 16'h8000, 1'b0});
    vecs.push_back('{"srl",      mk(4'd7,  16'h8000, 16'h000F), 16'h0001, 1'b0});
    vecs.push_back('{"seq",      mk(4'd8,  16'h1234, 16'h1234), 16'h0001, 1'b0});
    vecs.push_back('{"slt_t",    mk(4'd9,  16'hFFFF, 16'h0001), 16'h0001, 1'b0});
    vecs.push_back('{"slt_f",    mk(4'd9,  16'h0001, 16'hFFFF), 16'h0000, 1'b0});
    vecs.push_back('{"sle_eq",   mk(4'd10, 16'h8000, 16'h8000), 16'h0001, 1'b0});
    vecs.push_back('{"sco_1",    mk(4'd11, 16'hFFFF, 16'h0001), 16'h0001, 1'b0});
    vecs.push_back('{"sco_0",    mk(4'd11, 16'h7FFF, 16'h0001), 16'h0000, 1'b0});
    vecs.push_back('{"ill_f",    mk(4'd15, 16'h0005, 16'h0003), 16'h0000, 1'b1});
    vecs.push_back('{"ill_e",    mk(4'd14, 16'h0005, 16'h0003), 16'h0000, 1'b1});
`ifndef EXEC_MUL_EN
    vecs.push_back('{"mul_ill",  mk(4'd12, 16'h0007, 16'h0006), 16'h0000, 1'b1});
`endif
    x = mk(4'd13, 16'h0000, 16'h0000); x.src_imm = 1'b1; x.imm = 16'hBEEF;
    vecs.push_back('{"passb_imm", x, 16'hBEEF, 1'b0});
    x = mk(4'd0, 16'h0010, 16'h0001); x.src_imm = 1'b1; x.imm = 16'hFFFF;
    vecs.push_back('{"add_imm",   x, 16'h000F, 1'b0});

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      v.i.rd = 3'(k); v.i.wr = k[0];
      send(v.i, v.name);
      chk({v.name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({v.name, "_result"}, 32'(bus.out_result), 32'(v.res));
      chk({v.name, "_err"}, 32'(bus.out_err), 32'(v.err));
      chk({v.name, "_rd_wr"}, {28'd0, bus.out_rd, bus.out_wr_en}, {28'(k[2:0]), k[0]});
    end
    @(posedge clk); #1;
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: result must hold and input stall until consumed once.
    bus.out_ready = 1'b0;
    send(mk(4'd1, 16'h0003, 16'h0005), "bp_sub");
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_result", 32'(bus.out_result), 32'hFFFE);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_ready_released", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Taken BEQZ, then not-taken: pulse is one cycle, target sticks.
    x = mk(4'd0, 16'h0000, 16'h0000); x.is_br = 1'b1; x.cond = 2'b00;
    x.pc = 16'h0010; x.off = 16'hFFFC;
    send(x, "beqz_t");
    chk("beqz_t_redirect", 32'(bus.redirect), 32'd1);
    chk("beqz_t_pc", 32'(bus.redirect_pc), 32'h000C);
    @(posedge clk); #1;
    chk("beqz_pulse_end", 32'(bus.redirect), 32'd0);
    chk("beqz_pc_hold", 32'(bus.redirect_pc), 32'h000C);
    x.a = 16'h0001;
    send(x, "beqz_nt");
    chk("beqz_nt_redirect", 32'(bus.redirect), 32'd0);
    chk("beqz_nt_pc_hold", 32'(bus.redirect_pc), 32'h000C);

    // Register-relative jump with wrap; is_br also set, jump wins.
    x = mk(4'd3, 16'hFFFE, 16'h0000); x.is_jmp = 1'b1; x.jreg = 1'b1; x.is_br = 1'b1;
    x.cond = 2'b01; x.off = 16'h0004; x.pc = 16'h0020;
    send(x, "jalr");
    chk("jalr_redirect", 32'(bus.redirect), 32'd1);
    chk("jalr_pc", 32'(bus.redirect_pc), 32'h0002);
    chk("jalr_result", 32'(bus.out_result), 32'h0020);
    chk("jalr_err", 32'(bus.out_err), 32'd0);

`ifdef EXEC_MUL_EN
    send(mk(4'd12, 16'h0007, 16'h0006), "mul");
    for (int k = 0; k < W; k++) begin
      chk("mul_busy_valid", 32'(bus.out_valid), 32'd0);
      chk("mul_busy_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("mul_busy_valid_last", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("mul_valid", 32'(bus.out_valid), 32'd1);
    chk("mul_result", 32'(bus.out_result), 32'h002A);
    chk("mul_err", 32'(bus.out_err), 32'd0);

    send(mk(4'd12, 16'h0007, 16'h0006), "mul_rst");
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mulrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mulrst_result", 32'(bus.out_result), 32'd0);
    chk("mulrst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("mulrst_aborted", 32'(seen), 32'd0);
`endif

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      cur = rand_instr();
      drive(cur);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b0;
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_final_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
